// File: rtl/fifo_pkg.sv
// Shared definitions for the BRAM-backed first-word-fall-through FIFO.
// Provides default geometry, the prefetch state encoding and a helper
// that sizes the occupancy counter (one extra bit to represent DEPTH).
package fifo_pkg;

  localparam int unsigned DEF_WIDTH  = 288;
  localparam int unsigned DEF_ADDR_W = 2;

  // Output-stage prefetch states
  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_HOLD  = 2'd2
  } pf_state_t;

  // Counter width able to hold 0..2**addr_w inclusive
  function automatic int unsigned count_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sdp_bram.sv
// Simple-dual-port block RAM with one write port and one registered read port.
// Ports:
//   clk              - clock, rising edge
//   wr_en/wr_adr/wr_dt - write strobe, address, data
//   rd_en/rd_adr     - read strobe and address
//   rd_dt            - read data, registered (valid the edge after rd_en)
// Contents are not reset.
module sdp_bram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [WIDTH-1:0]  wr_dt,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_adr,
  output logic [WIDTH-1:0]  rd_dt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_adr] <= wr_dt;
    end
    if (rd_en) begin
      rd_dt <= mem[rd_adr];
    end
  end

endmodule

// File: rtl/fifo_bram_fwft.sv
// Synchronous FWFT FIFO over a simple-dual-port block RAM.
// A two-deep read pipeline (RAM read register + output register) hides the
// RAM read latency so a stored word follows a pop with no bubble.
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   clr               - synchronous flush (also clears sticky errors)
//   wr_valid/wr_ready/wr_data - producer handshake; wr_ready == !full
//   rd_valid/rd_ready/rd_data - consumer handshake; rd_data is the head word
//   count             - words accepted and not yet popped (0..DEPTH)
//   full, empty, almost_full, almost_empty - registered occupancy flags
//   overflow, underflow - sticky protocol error flags
module fifo_bram_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned AF_LEVEL = (2 ** ADDR_W) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned   DEPTH   = 2 ** ADDR_W;
  localparam int unsigned   CW      = count_width(ADDR_W);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic          AF_RST  = (AF_LEVEL == 0);

  pf_state_t state, state_nxt;

  // Pointers carry one wrap bit so "all DEPTH words unread" differs from "none"
  logic [ADDR_W:0]    wr_ptr, rd_ptr;
  logic               fl_valid, fl_valid_nxt;
  logic [CW-1:0]      count_nxt;
  logic               push, pop, unread, adv, issue;
  logic [WIDTH-1:0]   ram_rd_dt;

  sdp_bram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push),
    .wr_adr (wr_ptr[ADDR_W-1:0]),
    .wr_dt  (wr_data),
    .rd_en  (issue),
    .rd_adr (rd_ptr[ADDR_W-1:0]),
    .rd_dt  (ram_rd_dt)
  );

  // Prefetch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PF_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake decode, prefetch control and next state
  always_comb begin
    push         = 1'b0;
    pop          = 1'b0;
    unread       = 1'b0;
    adv          = 1'b0;
    issue        = 1'b0;
    fl_valid_nxt = fl_valid;
    count_nxt    = count;
    state_nxt    = state;

    push   = wr_valid && wr_ready && !clr;
    pop    = rd_valid && rd_ready && !clr;
    // Registered pointers: a word written this edge is only read from next cycle
    unread = (wr_ptr != rd_ptr);
    // RAM read register moves to the output when the output is free or popped
    adv    = fl_valid && (state != PF_HOLD || pop);
    // Keep the read register full whenever the RAM has something for it
    issue  = !clr && unread && (!fl_valid || adv);

    fl_valid_nxt = issue || (fl_valid && !adv);

    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end

    case (state)
      PF_IDLE: begin
        if (issue) begin
          state_nxt = PF_FETCH;
        end
      end
      PF_FETCH: begin
        if (adv) begin
          state_nxt = PF_HOLD;
        end
      end
      PF_HOLD: begin
        // A word already in the read register refills the output directly
        if (pop && !fl_valid) begin
          state_nxt = issue ? PF_FETCH : PF_IDLE;
        end
      end
      default: state_nxt = PF_IDLE;
    endcase

    if (clr) begin
      state_nxt    = PF_IDLE;
      fl_valid_nxt = 1'b0;
      count_nxt    = '0;
    end
  end

  // Pointers, occupancy, flags and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fl_valid     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      wr_ready     <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fl_valid     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      wr_ready     <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
      if (adv) begin
        rd_data <= ram_rd_dt;
      end
      fl_valid     <= fl_valid_nxt;
      rd_valid     <= (state_nxt == PF_HOLD);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      wr_ready     <= (count_nxt != DEPTH_C);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end
      if (rd_ready && !rd_valid) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
